// File: rtl/vend_pkg.sv
// Shared types and coin encoding for the vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_R1   = 2'b01;
  localparam logic [1:0] COIN_R2   = 2'b10;
  localparam logic [1:0] COIN_R5   = 2'b11;

  localparam int COIN_VAL_W = 4;

  function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_R1: return COIN_VAL_W'(1);
      COIN_R2: return COIN_VAL_W'(2);
      COIN_R5: return COIN_VAL_W'(5);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/vend_idle_timer.sv
// Counts idle cycles while enabled; flags the cycle whose edge completes TIMEOUT idle cycles.
module vend_idle_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_cnt <= '0;
    else if (i_clr || !i_en) r_cnt <= '0;
    else                    r_cnt <= r_cnt + TW'(1);
  end

  // Fires during the TIMEOUT-th idle cycle so the refund starts on that edge.
  assign o_expired = i_en && !i_clr && (r_cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/vend_controller.sv
// Vending controller: coin credit, product select, dispenser and change-hopper handshakes.
module vend_controller
  import vend_pkg::*;
#(
  parameter int NUM_PROD = 4,
  parameter int CREDIT_W = 4,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES = {4'd5, 4'd4, 4'd3, 4'd2},
  parameter int TIMEOUT = 255,
  localparam int SEL_W = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_id,
  input  logic                cancel,
  input  logic                disp_ack,
  input  logic                chg_ack,
  output logic                disp_req,
  output logic [SEL_W-1:0]    disp_id,
  output logic                chg_req,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_rej,
  output logic                sel_rej
);

  state_t              r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic [SEL_W-1:0]    r_disp_id, w_disp_id_nxt;
  logic                r_coin_rej, w_coin_rej_nxt;
  logic                r_sel_rej, w_sel_rej_nxt;

  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_avail;
  logic [CREDIT_W-1:0] w_price_sel;
  logic [CREDIT_W-1:0] w_price_disp;
  logic                w_sel_ok;
  logic                w_cancel_act;
  logic                w_expired;
  logic                w_tmr_clr;
  logic                w_tmr_en;

  assign w_sum        = {1'b0, r_credit} + (CREDIT_W+1)'(coin_value(coin));
  assign w_price_sel  = PRICES[int'(sel_id)*CREDIT_W +: CREDIT_W];
  assign w_price_disp = PRICES[int'(r_disp_id)*CREDIT_W +: CREDIT_W];

  generate
    if (NUM_PROD == (1 << SEL_W)) begin : g_sel_full
      assign w_sel_ok = 1'b1;
    end else begin : g_sel_part
      assign w_sel_ok = (sel_id < SEL_W'(NUM_PROD));
    end
  endgenerate

  assign w_tmr_en  = (r_state == ST_COLLECT);
  assign w_tmr_clr = (coin != COIN_NONE) || sel_valid;

  vend_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_credit   <= '0;
      r_disp_id  <= '0;
      r_coin_rej <= 1'b0;
      r_sel_rej  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_credit   <= w_credit_nxt;
      r_disp_id  <= w_disp_id_nxt;
      r_coin_rej <= w_coin_rej_nxt;
      r_sel_rej  <= w_sel_rej_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_credit_nxt   = r_credit;
    w_disp_id_nxt  = r_disp_id;
    w_coin_rej_nxt = 1'b0;
    w_sel_rej_nxt  = 1'b0;
    w_avail        = r_credit;
    w_cancel_act   = 1'b0;
    case (r_state)
      ST_IDLE, ST_COLLECT: begin
        w_cancel_act = cancel && (r_state == ST_COLLECT);
        if (coin != COIN_NONE) begin
          if (w_cancel_act || w_sum[CREDIT_W]) w_coin_rej_nxt = 1'b1;
          else                                 w_avail = w_sum[CREDIT_W-1:0];
        end
        w_credit_nxt = w_avail;
        if (w_avail != '0) w_state_nxt = ST_COLLECT;
        // Select sees the credit including a coin accepted in the same cycle.
        if (w_cancel_act) begin
          w_state_nxt = ST_CHANGE;
        end else if (sel_valid) begin
          if (w_sel_ok && (w_avail >= w_price_sel)) begin
            w_state_nxt   = ST_VEND;
            w_disp_id_nxt = sel_id;
          end else begin
            w_sel_rej_nxt = 1'b1;
          end
        end else if (w_expired) begin
          w_state_nxt = ST_CHANGE;
        end
      end
      ST_VEND: begin
        w_coin_rej_nxt = (coin != COIN_NONE);
        if (disp_ack) begin
          w_credit_nxt = (r_credit >= w_price_disp) ? (r_credit - w_price_disp) : '0;
          w_state_nxt  = (w_credit_nxt != '0) ? ST_CHANGE : ST_IDLE;
        end
      end
      ST_CHANGE: begin
        w_coin_rej_nxt = (coin != COIN_NONE);
        if (r_credit == '0) begin
          w_state_nxt = ST_IDLE;
        end else if (chg_ack) begin
          w_credit_nxt = r_credit - CREDIT_W'(1);
          if (r_credit == CREDIT_W'(1)) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign disp_req = (r_state == ST_VEND);
  assign chg_req  = (r_state == ST_CHANGE);
  assign busy     = (r_state == ST_VEND) || (r_state == ST_CHANGE);
  assign disp_id  = r_disp_id;
  assign credit   = r_credit;
  assign coin_rej = r_coin_rej;
  assign sel_rej  = r_sel_rej;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller (prices p0..p3 = 2,3,4,5; TIMEOUT = 8).
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] coin = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_id = 2'd0;
  logic       cancel = 1'b0;
  logic       disp_ack = 1'b0;
  logic       chg_ack = 1'b0;
  logic       disp_req;
  logic [1:0] disp_id;
  logic       chg_req;
  logic [3:0] credit;
  logic       busy;
  logic       coin_rej;
  logic       sel_rej;

  int n_chk = 0;
  int n_err = 0;

  vend_controller #(
    .NUM_PROD (4),
    .CREDIT_W (4),
    .PRICES   (16'h5432),
    .TIMEOUT  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .coin      (coin),
    .sel_valid (sel_valid),
    .sel_id    (sel_id),
    .cancel    (cancel),
    .disp_ack  (disp_ack),
    .chg_ack   (chg_ack),
    .disp_req  (disp_req),
    .disp_id   (disp_id),
    .chg_req   (chg_req),
    .credit    (credit),
    .busy      (busy),
    .coin_rej  (coin_rej),
    .sel_rej   (sel_rej)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given one-cycle inputs; returns 1 time unit after the edge.
  task automatic tick(input logic [1:0] c, input logic sv, input logic [1:0] sid,
                      input logic cn, input logic da, input logic ca);
    coin = c; sel_valid = sv; sel_id = sid; cancel = cn; disp_ack = da; chg_ack = ca;
    @(posedge clk);
    #1;
    coin = 2'b00; sel_valid = 1'b0; cancel = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0;
  endtask

  task automatic put(input logic [1:0] c);
    tick(c, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sel(input logic [1:0] sid);
    tick(2'b00, 1'b1, sid, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    tick(2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic dack();
    tick(2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic cack();
    tick(2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #12;
    chk("rst_credit", credit, 0);
    chk("rst_disp_req", disp_req, 0);
    chk("rst_chg_req", chg_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_coin_rej", coin_rej, 0);
    chk("rst_sel_rej", sel_rej, 0);
    @(negedge clk);
    rst = 1'b0;

    // Exact pay: 2 + 1 = 3, product 1 costs 3.
    put(2'b10);
    chk("exact_c2", credit, 2);
    put(2'b01);
    chk("exact_c3", credit, 3);
    sel(2'd1);
    chk("exact_disp_req", disp_req, 1);
    chk("exact_disp_id", disp_id, 1);
    chk("exact_busy", busy, 1);
    dack();
    chk("exact_credit0", credit, 0);
    chk("exact_req_drop", disp_req, 0);
    chk("exact_no_chg", chg_req, 0);
    chk("exact_idle", busy, 0);

    // Overpay: 5 for product 0 (price 2) leaves 3 coins of change.
    put(2'b11);
    chk("over_c5", credit, 5);
    sel(2'd0);
    chk("over_disp_req", disp_req, 1);
    idle();
    chk("over_req_held", disp_req, 1);
    dack();
    chk("over_chg_req", chg_req, 1);
    chk("over_rem3", credit, 3);
    chk("over_disp_drop", disp_req, 0);
    cack();
    chk("over_c2", credit, 2);
    tick(2'b01, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("chg_coin_rej", coin_rej, 1);
    chk("chg_sel_norej", sel_rej, 0);
    chk("chg_hold_c2", credit, 2);
    cack();
    chk("over_c1", credit, 1);
    chk("chg_rej_pulse", coin_rej, 0);
    cack();
    chk("over_c0", credit, 0);
    chk("over_chg_drop", chg_req, 0);
    chk("over_idle", busy, 0);

    // Insufficient credit, then saturation at 12 + 5 > 15.
    put(2'b10);
    sel(2'd3);
    chk("insuf_sel_rej", sel_rej, 1);
    chk("insuf_credit", credit, 2);
    chk("insuf_no_vend", disp_req, 0);
    put(2'b11);
    chk("sat_c7", credit, 7);
    chk("sel_rej_pulse", sel_rej, 0);
    put(2'b11);
    chk("sat_c12", credit, 12);
    chk("sat_no_rej", coin_rej, 0);
    put(2'b11);
    chk("sat_coin_rej", coin_rej, 1);
    chk("sat_credit", credit, 12);
    tick(2'b00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("sat_cancel_chg", chg_req, 1);
    for (int i = 0; i < 12; i++) begin
      cack();
      chk("sat_drain", credit, 11 - i);
    end
    chk("sat_idle", busy, 0);

    // Cancel ignored in IDLE; cancel at credit 4 refunds four coins.
    tick(2'b00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("idle_cancel", chg_req, 0);
    put(2'b10);
    put(2'b10);
    chk("cancel_c4", credit, 4);
    tick(2'b00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("cancel_chg", chg_req, 1);
    chk("cancel_credit", credit, 4);
    for (int i = 0; i < 4; i++) begin
      cack();
      chk("cancel_drain", credit, 3 - i);
    end
    chk("cancel_idle", chg_req, 0);

    // Timeout: 8 idle cycles in COLLECT start a refund.
    put(2'b01);
    chk("to_c1", credit, 1);
    repeat (7) idle();
    chk("to_not_yet", busy, 0);
    idle();
    chk("to_chg", chg_req, 1);
    chk("to_credit", credit, 1);
    cack();
    chk("to_c0", credit, 0);
    chk("to_idle", busy, 0);

    // Coin and select together: 1 + 2 = 3 covers product 0.
    put(2'b01);
    tick(2'b10, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("sim_vend", disp_req, 1);
    chk("sim_credit", credit, 3);
    chk("sim_disp_id", disp_id, 0);
    dack();
    chk("sim_rem1", credit, 1);
    chk("sim_chg", chg_req, 1);
    cack();
    chk("sim_c0", credit, 0);

    // Cancel beats select; the same-cycle coin is refused.
    put(2'b10);
    put(2'b01);
    tick(2'b01, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("csc_coin_rej", coin_rej, 1);
    chk("csc_sel_rej", sel_rej, 0);
    chk("csc_chg", chg_req, 1);
    chk("csc_no_vend", disp_req, 0);
    chk("csc_credit", credit, 3);
    repeat (3) cack();
    chk("csc_c0", credit, 0);
    chk("csc_idle", busy, 0);

    // Asynchronous reset in the middle of a vend.
    put(2'b10);
    put(2'b10);
    sel(2'd1);
    chk("ar_vend", disp_req, 1);
    chk("ar_c4", credit, 4);
    #2 rst = 1'b1;
    #1;
    chk("ar_disp_req", disp_req, 0);
    chk("ar_credit", credit, 0);
    chk("ar_busy", busy, 0);
    #1 rst = 1'b0;
    put(2'b01);
    chk("ar_post_c1", credit, 1);
    chk("ar_post_busy", busy, 0);
    chk("ar_post_req", disp_req, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
